// File: rtl/sd_block_server.sv
// sd_block_server
// ---------------------------------------------------------------------------
// Simulation-side responder for the MiSTer sector handshake. It serves
// 512-byte sectors for two drives (0 = floppy, 1 = HDD) out of a flat
// byte-wide image store, and turns host mount pulses into the
// img_mounted / img_size / img_readonly status seen by the emu core.
//
// Ports
//   clk_sys, reset             system clock, asynchronous active-high reset
//   sd_lba0/1, sd_rd, sd_wr    per-drive sector number and level requests
//   sd_buff_din0/1             requester buffer data (valid 1 cycle after addr)
//   sd_ack                     per-drive transfer-in-progress
//   sd_buff_addr/dout/wr       byte index, read data and read strobe
//   mount_req/size/ro          host mount pulse, image size, read-only flag
//   img_mounted/size/readonly  mount status towards the emu
//   img_addr/rd/rdata          image store read port (1-cycle latency)
//   img_we/wdata               image store write port
//
// Store address layout: {drive, lba[LBA_W-1:0], byte[8:0]}.
// ---------------------------------------------------------------------------
module sd_block_server #(
    parameter int LBA_W = 12,
    parameter int GAP   = 4
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [31:0]        sd_lba0,
    input  logic [31:0]        sd_lba1,
    input  logic [1:0]         sd_rd,
    input  logic [1:0]         sd_wr,
    input  logic [7:0]         sd_buff_din0,
    input  logic [7:0]         sd_buff_din1,
    output logic [1:0]         sd_ack,
    output logic [8:0]         sd_buff_addr,
    output logic [7:0]         sd_buff_dout,
    output logic               sd_buff_wr,
    input  logic [1:0]         mount_req,
    input  logic [63:0]        mount_size,
    input  logic               mount_ro,
    output logic [1:0]         img_mounted,
    output logic [63:0]        img_size,
    output logic               img_readonly,
    output logic [LBA_W+9:0]   img_addr,
    output logic               img_rd,
    input  logic [7:0]         img_rdata,
    output logic               img_we,
    output logic [7:0]         img_wdata
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_GAP} state_t;

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t             state_q, state_d;
    logic [8:0]         cnt_q, cnt_d;
    logic               drv_q, drv_d;
    logic               wr_op_q, wr_op_d;
    logic [LBA_W-1:0]   lba_q, lba_d;
    logic               oob_q, oob_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         ack_q, ack_d;
    logic [8:0]         buff_addr_q, buff_addr_d;
    logic               buff_wr_q, buff_wr_d;
    logic [LBA_W+9:0]   img_addr_q, img_addr_d;
    logic               img_rd_q, img_rd_d;
    logic               img_we_q, img_we_d;
    logic [1:0]         mounted_q, mounted_d;
    logic [63:0]        size_q, size_d;
    logic               ro_q, ro_d;

    // Per-drive request view and bounds check.
    logic [1:0][31:0]   lba_in;
    logic [1:0]         oob_in;
    logic [63:0]        sectors;

    assign lba_in[0] = sd_lba0;
    assign lba_in[1] = sd_lba1;
    assign sectors   = {9'd0, size_q[63:9]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bounds
            // Out of range if past the mounted image or too wide for the store.
            assign oob_in[gi] = ({32'd0, lba_in[gi]} >= sectors) ||
                                (lba_in[gi][31:LBA_W] != '0);
        end
    endgenerate

    // Drive 0 has priority; within a drive a read beats a write.
    logic pick;
    logic any_req;
    assign any_req = |(sd_rd | sd_wr);
    assign pick    = ~(sd_rd[0] | sd_wr[0]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drv_d       = drv_q;
        wr_op_d     = wr_op_q;
        lba_d       = lba_q;
        oob_d       = oob_q;
        gap_d       = gap_q;
        ack_d       = ack_q;
        buff_addr_d = '0;
        buff_wr_d   = 1'b0;
        img_addr_d  = '0;
        img_rd_d    = 1'b0;
        img_we_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d    = S_XFER;
                    drv_d      = pick;
                    wr_op_d    = ~sd_rd[pick];
                    lba_d      = lba_in[pick][LBA_W-1:0];
                    oob_d      = oob_in[pick];
                    cnt_d      = '0;
                    ack_d      = pick ? 2'b10 : 2'b01;
                    // First read address goes out together with the ack rise;
                    // for a write, buff_addr 0 is the default above.
                    img_rd_d   = sd_rd[pick];
                    img_addr_d = {pick, lba_in[pick][LBA_W-1:0], 9'd0};
                end
            end

            S_XFER: begin
                if (wr_op_q) begin
                    // Requester data for cnt_q arrives now; store it while
                    // presenting the next buffer address.
                    img_we_d    = ~oob_q & ~ro_q;
                    img_addr_d  = {drv_q, lba_q, cnt_q};
                    buff_addr_d = cnt_q + 9'd1;
                end else begin
                    // Store data for cnt_q arrives next cycle, aligned with
                    // the strobe; prefetch the following byte meanwhile.
                    buff_wr_d   = 1'b1;
                    buff_addr_d = cnt_q;
                    if (cnt_q != 9'd511) begin
                        img_rd_d   = 1'b1;
                        img_addr_d = {drv_q, lba_q, cnt_q + 9'd1};
                    end
                end
                if (cnt_q == 9'd511) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end

            S_DRAIN: begin
                ack_d   = 2'b00;
                gap_d   = '0;
                state_d = S_GAP;
            end

            S_GAP: begin
                if (gap_q == GAP_W'(GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Mount status: one-cycle pulse per drive; size/ro come from the shared
    // mount_size/mount_ro inputs, so a simultaneous mount uses one value.
    always_comb begin
        mounted_d = mount_req;
        size_d    = size_q;
        ro_d      = ro_q;
        if (|mount_req) begin
            size_d = mount_size;
            ro_d   = mount_ro;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            drv_q       <= 1'b0;
            wr_op_q     <= 1'b0;
            lba_q       <= '0;
            oob_q       <= 1'b0;
            gap_q       <= '0;
            ack_q       <= '0;
            buff_addr_q <= '0;
            buff_wr_q   <= 1'b0;
            img_addr_q  <= '0;
            img_rd_q    <= 1'b0;
            img_we_q    <= 1'b0;
            mounted_q   <= '0;
            size_q      <= '0;
            ro_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drv_q       <= drv_d;
            wr_op_q     <= wr_op_d;
            lba_q       <= lba_d;
            oob_q       <= oob_d;
            gap_q       <= gap_d;
            ack_q       <= ack_d;
            buff_addr_q <= buff_addr_d;
            buff_wr_q   <= buff_wr_d;
            img_addr_q  <= img_addr_d;
            img_rd_q    <= img_rd_d;
            img_we_q    <= img_we_d;
            mounted_q   <= mounted_d;
            size_q      <= size_d;
            ro_q        <= ro_d;
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = buff_addr_q;
    assign sd_buff_wr   = buff_wr_q;
    assign img_addr     = img_addr_q;
    assign img_rd       = img_rd_q;
    assign img_we       = img_we_q;
    assign img_mounted  = mounted_q;
    assign img_size     = size_q;
    assign img_readonly = ro_q;

    // Both data paths are a registered select over data that is itself
    // registered at its source (store read register / requester buffer),
    // so they add no extra cycle and read as 0 whenever their strobe is low.
    assign sd_buff_dout = (buff_wr_q && !oob_q) ? img_rdata : 8'h00;
    assign img_wdata    = img_we_q ? (drv_q ? sd_buff_din1 : sd_buff_din0) : 8'h00;

endmodule

// File: tb/tb_sd_block_server.sv
`timescale 1ns/1ps
module tb_sd_block_server;

    localparam int LBA_W = 12;
    localparam int GAP   = 4;
    localparam int AW    = LBA_W + 10;

    logic              clk_sys = 1'b0;
    logic              reset   = 1'b1;
    logic [31:0]       sd_lba0 = '0;
    logic [31:0]       sd_lba1 = '0;
    logic [1:0]        sd_rd   = '0;
    logic [1:0]        sd_wr   = '0;
    logic [7:0]        sd_buff_din0;
    logic [7:0]        sd_buff_din1;
    logic [1:0]        sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic              sd_buff_wr;
    logic [1:0]        mount_req  = '0;
    logic [63:0]       mount_size = '0;
    logic              mount_ro   = 1'b0;
    logic [1:0]        img_mounted;
    logic [63:0]       img_size;
    logic              img_readonly;
    logic [AW-1:0]     img_addr;
    logic              img_rd;
    logic [7:0]        img_rdata;
    logic              img_we;
    logic [7:0]        img_wdata;

    sd_block_server #(.LBA_W(LBA_W), .GAP(GAP)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sd_lba0      (sd_lba0),
        .sd_lba1      (sd_lba1),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_buff_din0 (sd_buff_din0),
        .sd_buff_din1 (sd_buff_din1),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .mount_req    (mount_req),
        .mount_size   (mount_size),
        .mount_ro     (mount_ro),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .img_addr     (img_addr),
        .img_rd       (img_rd),
        .img_rdata    (img_rdata),
        .img_we       (img_we),
        .img_wdata    (img_wdata)
    );

    always #5 clk_sys = ~clk_sys;

    // Image store: unwritten bytes read as addr[7:0]; 1-cycle read latency.
    logic [7:0] mem [logic [AW-1:0]];

    function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0];
    endfunction

    // Requester buffers: byte k holds ~k, returned one cycle after the address.
    always @(posedge clk_sys) begin
        if (img_rd) img_rdata <= mem_rd(img_addr);
        if (img_we) mem[img_addr] = img_wdata;
        sd_buff_din0 <= ~sd_buff_addr[7:0];
        sd_buff_din1 <= ~sd_buff_addr[7:0];
    end

    // Expectations set by the stimulus process.
    logic             exp_oob  = 1'b0;
    logic [LBA_W:0]   exp_wsec = '0;

    // Monitor, sampling on the falling edge.
    int cyc = 0;
    logic [1:0] ack_prev = '0;
    int ack_rises [2] = '{0, 0};
    int rise_cyc  [2] = '{0, 0};
    int fall_cyc  [2] = '{-1, -1};
    int strobes = 0, rd_err = 0, we_cnt = 0, we_err = 0, both_err = 0;
    int first_wr_cyc = 0, first_we_cyc = 0;
    int rd_k = 0, we_k = 0;
    int lba_log [$];
    int gap_log [$];

    always @(negedge clk_sys) begin
        cyc++;
        if (sd_ack == 2'b11) both_err++;
        for (int d = 0; d < 2; d++) begin
            if (sd_ack[d] && !ack_prev[d]) begin
                ack_rises[d]++;
                if (d == 0 && fall_cyc[0] >= 0) gap_log.push_back(cyc - fall_cyc[0]);
                rise_cyc[d] = cyc;
                rd_k = 0;
                we_k = 0;
            end
            if (!sd_ack[d] && ack_prev[d]) begin
                fall_cyc[d] = cyc;
                $display("sector drv=%0d rise=%0d fall=%0d strobes=%0d writes=%0d",
                         d, rise_cyc[d], cyc, rd_k, we_k);
            end
        end
        if (img_rd && img_addr[8:0] == 9'd0) lba_log.push_back(int'(img_addr[LBA_W+8:9]));
        if (sd_buff_wr) begin
            if (rd_k == 0) first_wr_cyc = cyc;
            if (sd_buff_addr != rd_k[8:0] ||
                sd_buff_dout != (exp_oob ? 8'h00 : rd_k[7:0])) rd_err++;
            strobes++;
            rd_k++;
        end
        if (img_we) begin
            if (we_k == 0) first_we_cyc = cyc;
            if (img_addr != {exp_wsec, we_k[8:0]} || img_wdata != ~we_k[7:0]) we_err++;
            we_cnt++;
            we_k++;
        end
        ack_prev = sd_ack;
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Act 1ns after the falling edge, after the monitor has updated.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            #1;
        end
    endtask

    task automatic mount(input logic [1:0] d, input logic [63:0] size, input logic ro);
        mount_req  = d;
        mount_size = size;
        mount_ro   = ro;
        step(1);
        mount_req  = '0;
    endtask

    task automatic wait_rise(input int d, input int target, input string tag);
        int n = 0;
        while (ack_rises[d] < target && n < 1200) begin
            step(1);
            n++;
        end
        check_eq(tag, 64'(ack_rises[d]), 64'(target));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (sd_ack != 2'b00 && n < 1200) begin
            step(1);
            n++;
        end
        check_eq(tag, 64'(sd_ack), 64'd0);
        step(GAP + 3);
    endtask

    // One sector request held for one cycle past the ack rise.
    task automatic do_req(input int d, input logic [31:0] lba, input logic is_wr, input logic both);
        int tgt;
        tgt = ack_rises[d] + 1;
        if (d == 0) sd_lba0 = lba; else sd_lba1 = lba;
        if (is_wr) sd_wr[d] = 1'b1; else sd_rd[d] = 1'b1;
        if (both) sd_wr[d] = 1'b1;
        wait_rise(d, tgt, "req_ack");
        step(1);
        sd_rd[d] = 1'b0;
        sd_wr[d] = 1'b0;
        wait_idle("req_done");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s_str, s_err, s_lba, s_gap, s_r0, s_r1, s_we, s_wer, bad, n;
        logic [AW-1:0] wb;

        // Reset state
        step(3);
        check_eq("rst_ack",   64'(sd_ack), 64'd0);
        check_eq("rst_wr",    64'(sd_buff_wr), 64'd0);
        check_eq("rst_size",  img_size, 64'd0);
        check_eq("rst_misc",  64'({img_rd, img_we, img_mounted, img_readonly}), 64'd0);
        reset = 1'b0;
        step(2);

        // Single read, drive 0, lba 2
        mount(2'b01, 64'd232960, 1'b0);
        check_eq("mount0_pulse", 64'(img_mounted), 64'd1);
        step(1);
        check_eq("mount0_clear", 64'(img_mounted), 64'd0);
        check_eq("mount0_size",  img_size, 64'd232960);
        check_eq("mount0_ro",    64'(img_readonly), 64'd0);
        s_str = strobes; s_err = rd_err; s_r0 = ack_rises[0];
        exp_oob = 1'b0;
        do_req(0, 32'd2, 1'b0, 1'b0);
        check_eq("t1_acks",     64'(ack_rises[0] - s_r0), 64'd1);
        check_eq("t1_strobes",  64'(strobes - s_str), 64'd512);
        check_eq("t1_data",     64'(rd_err - s_err), 64'd0);
        check_eq("t1_lba",      64'(lba_log[lba_log.size() - 1]), 64'd2);
        check_eq("t1_ack_len",  64'(fall_cyc[0] - rise_cyc[0]), 64'd513);
        check_eq("t1_first_wr", 64'(first_wr_cyc - rise_cyc[0]), 64'd1);

        // Multi-sector streaming: lba advanced on every ack rise
        s_r0 = ack_rises[0]; s_lba = lba_log.size(); s_gap = gap_log.size(); s_str = strobes;
        sd_lba0  = 32'd0;
        sd_rd[0] = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            wait_rise(0, s_r0 + i, "t2_ack");
            if (i == 13) sd_rd[0] = 1'b0; else sd_lba0 = 32'(i);
        end
        wait_idle("t2_done");
        check_eq("t2_acks",      64'(ack_rises[0] - s_r0), 64'd13);
        check_eq("t2_lba_count", 64'(lba_log.size() - s_lba), 64'd13);
        bad = 0;
        for (int i = 0; i < 13; i++) begin
            if (s_lba + i >= lba_log.size() || lba_log[s_lba + i] != i) bad++;
        end
        check_eq("t2_lba_order", 64'(bad), 64'd0);
        bad = 0;
        for (int i = 1; i < 13; i++) begin
            if (s_gap + i >= gap_log.size() || gap_log[s_gap + i] != GAP + 1) bad++;
        end
        check_eq("t2_gap", 64'(bad), 64'd0);
        check_eq("t2_strobes", 64'(strobes - s_str), 64'd6656);

        // Write, drive 1, lba 5
        mount(2'b10, 64'd232960, 1'b0);
        check_eq("mount1_pulse", 64'(img_mounted), 64'd2);
        exp_wsec = {1'b1, 12'd5};
        wb = {1'b1, 12'd5, 9'd0};
        s_we = we_cnt; s_wer = we_err; s_r1 = ack_rises[1]; s_str = strobes;
        do_req(1, 32'd5, 1'b1, 1'b0);
        check_eq("t3_acks",      64'(ack_rises[1] - s_r1), 64'd1);
        check_eq("t3_writes",    64'(we_cnt - s_we), 64'd512);
        check_eq("t3_wdata",     64'(we_err - s_wer), 64'd0);
        check_eq("t3_ack_len",   64'(fall_cyc[1] - rise_cyc[1]), 64'd513);
        check_eq("t3_first_we",  64'(first_we_cyc - rise_cyc[1]), 64'd1);
        check_eq("t3_no_strobe", 64'(strobes - s_str), 64'd0);
        check_eq("t3_store0",    64'(mem_rd(wb)), 64'hFF);
        check_eq("t3_store511",  64'(mem_rd(wb + AW'(511))), 64'h00);

        // Same write with the image read-only
        mount(2'b10, 64'd232960, 1'b1);
        check_eq("mount1_ro", 64'(img_readonly), 64'd1);
        s_we = we_cnt; s_r1 = ack_rises[1];
        do_req(1, 32'd5, 1'b1, 1'b0);
        check_eq("t3ro_acks",    64'(ack_rises[1] - s_r1), 64'd1);
        check_eq("t3ro_writes",  64'(we_cnt - s_we), 64'd0);
        check_eq("t3ro_ack_len", 64'(fall_cyc[1] - rise_cyc[1]), 64'd513);

        // Out of range: 1024-byte image has sectors 0 and 1 only
        mount(2'b01, 64'd1024, 1'b0);
        exp_oob = 1'b1;
        s_str = strobes; s_err = rd_err;
        do_req(0, 32'd2, 1'b0, 1'b0);
        check_eq("t4_oob_strobes", 64'(strobes - s_str), 64'd512);
        check_eq("t4_oob_zero",    64'(rd_err - s_err), 64'd0);
        exp_oob = 1'b0;
        s_str = strobes; s_err = rd_err;
        do_req(0, 32'd1, 1'b0, 1'b0);
        check_eq("t4_last_strobes", 64'(strobes - s_str), 64'd512);
        check_eq("t4_last_data",    64'(rd_err - s_err), 64'd0);

        // Contention: both drives request in the same cycle
        mount(2'b11, 64'd232960, 1'b0);
        check_eq("mount_both", 64'(img_mounted), 64'd3);
        s_r0 = ack_rises[0]; s_r1 = ack_rises[1];
        sd_lba0 = 32'd0;
        sd_lba1 = 32'd3;
        sd_rd   = 2'b11;
        wait_rise(0, s_r0 + 1, "t5_ack0");
        step(1);
        sd_rd[0] = 1'b0;
        wait_rise(1, s_r1 + 1, "t5_ack1");
        step(1);
        sd_rd[1] = 1'b0;
        wait_idle("t5_done");
        check_eq("t5_acks0",    64'(ack_rises[0] - s_r0), 64'd1);
        check_eq("t5_spacing",  64'(rise_cyc[1] - fall_cyc[0]), 64'(GAP + 1));
        check_eq("t5_exclusive", 64'(both_err), 64'd0);

        // Read and write on the same drive: the read wins
        s_str = strobes; s_we = we_cnt;
        do_req(0, 32'd7, 1'b0, 1'b1);
        check_eq("t5_rw_strobes", 64'(strobes - s_str), 64'd512);
        check_eq("t5_rw_writes",  64'(we_cnt - s_we), 64'd0);

        // Reset in the middle of a read
        sd_lba0  = 32'd4;
        sd_rd[0] = 1'b1;
        n = 0;
        while (!(sd_buff_wr && sd_buff_addr == 9'd300) && n < 1200) begin
            step(1);
            n++;
        end
        check_eq("t6_byte300", 64'(sd_buff_addr), 64'd300);
        sd_rd[0] = 1'b0;
        mount(2'b01, 64'd232960, 1'b0);
        check_eq("t6_mounted_pre", 64'(img_mounted), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_ack",     64'(sd_ack), 64'd0);
        check_eq("t6_rst_wr",      64'(sd_buff_wr), 64'd0);
        check_eq("t6_rst_mounted", 64'(img_mounted), 64'd0);
        check_eq("t6_rst_size",    img_size, 64'd0);
        check_eq("t6_rst_rd",      64'({img_rd, img_we}), 64'd0);
        step(2);
        reset = 1'b0;
        step(1);
        mount(2'b01, 64'd232960, 1'b0);
        step(1);
        s_str = strobes; s_err = rd_err;
        do_req(0, 32'd4, 1'b0, 1'b0);
        check_eq("t6_restart_strobes", 64'(strobes - s_str), 64'd512);
        check_eq("t6_restart_data",    64'(rd_err - s_err), 64'd0);
        check_eq("t6_restart_first",   64'(first_wr_cyc - rise_cyc[0]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
